// File: rtl/cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter
//
// Two-requester front end for the set-associative cache model.
//
// Requests from two sources (typically the instruction and data streams) are
// arbitrated round-robin. One lookup at a time is issued to the cache core.
// A miss is modelled as a fixed refill stall of MISS_PENALTY cycles. Each
// served request produces a one-cycle hit/miss response pulse.
//
// Build option:
//   CACHE_ARB_STATS_EN - when defined, per-source saturating hit/miss
//                        counters are built. When undefined, the four
//                        statistics outputs are tied to zero and no counter
//                        logic is generated.
//
// Parameters:
//   ADDR_W        request / lookup address width
//   MISS_PENALTY  refill stall after a miss, in cycles (0..255)
//   CNT_W         statistics counter width
//
// Ports:
//   clk_41          single clock, rising edge
//   rst_41          synchronous active-high reset
//   req0_valid_41   source 0 request valid
//   req0_addr_41    source 0 request address
//   req0_ready_41   source 0 accepted this cycle (combinational, IDLE only)
//   req1_valid_41   source 1 request valid
//   req1_addr_41    source 1 request address
//   req1_ready_41   source 1 accepted this cycle (combinational, IDLE only)
//   lk_valid_41     lookup request to the cache core
//   lk_addr_41      lookup address, latched at acceptance
//   lk_done_41      cache core result valid (looked at only while lk_valid_41)
//   lk_hit_41       cache core result: 1 = hit, 0 = miss
//   resp_valid_41   one-cycle response pulse
//   resp_src_41     source the response belongs to
//   resp_hit_41     hit/miss result of the response
//   busy_41         high in every state except IDLE
//   hits0_41        source 0 hit count
//   misses0_41      source 0 miss count
//   hits1_41        source 1 hit count
//   misses1_41      source 1 miss count
// ---------------------------------------------------------------------------
module cache_req_arbiter #(
  parameter int ADDR_W       = 31,
  parameter int MISS_PENALTY = 8,
  parameter int CNT_W        = 31
) (
  input  logic              clk_41,
  input  logic              rst_41,

  input  logic              req0_valid_41,
  input  logic [ADDR_W-1:0] req0_addr_41,
  output logic              req0_ready_41,

  input  logic              req1_valid_41,
  input  logic [ADDR_W-1:0] req1_addr_41,
  output logic              req1_ready_41,

  output logic              lk_valid_41,
  output logic [ADDR_W-1:0] lk_addr_41,
  input  logic              lk_done_41,
  input  logic              lk_hit_41,

  output logic              resp_valid_41,
  output logic              resp_src_41,
  output logic              resp_hit_41,

  output logic              busy_41,

  output logic [CNT_W-1:0]  hits0_41,
  output logic [CNT_W-1:0]  misses0_41,
  output logic [CNT_W-1:0]  hits1_41,
  output logic [CNT_W-1:0]  misses1_41
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // The refill counter is loaded with MISS_PENALTY-1 so that the REFILL
  // dwell (counting down to and including zero) is exactly MISS_PENALTY
  // cycles. With a zero penalty the REFILL state is never entered and the
  // load value is irrelevant.
  localparam logic [7:0] REFILL_LOAD =
    (MISS_PENALTY > 0) ? 8'(MISS_PENALTY - 1) : 8'd0;
  localparam bit NO_PENALTY = (MISS_PENALTY == 0);

  state_t     state;
  logic       rr;
  logic       cur_src;
  logic [7:0] refill_cnt;

  logic       any_valid;
  logic       grant_src;

  // Grant selection: with both sources pending the round-robin pointer
  // decides, otherwise the single pending source wins. When neither is
  // pending grant_src is a don't-care because any_valid gates the readies.
  assign any_valid = req0_valid_41 | req1_valid_41;
  assign grant_src = (req0_valid_41 && req1_valid_41) ? rr : req1_valid_41;

  // Readies are combinational so a source sees acceptance in the same
  // cycle it presents its request; they can only rise while idle.
  assign req0_ready_41 = (state == ST_IDLE) && any_valid && !grant_src;
  assign req1_ready_41 = (state == ST_IDLE) && any_valid &&  grant_src;

  // Main controller. All visible control outputs (lookup valid, response
  // pulse, busy) are registered alongside the state so they change only on
  // state transitions. Reset drops any in-flight request without answering.
  always_ff @(posedge clk_41) begin
    if (rst_41) begin
      state         <= ST_IDLE;
      rr            <= 1'b0;
      cur_src       <= 1'b0;
      refill_cnt    <= 8'd0;
      lk_valid_41   <= 1'b0;
      lk_addr_41    <= '0;
      resp_valid_41 <= 1'b0;
      resp_src_41   <= 1'b0;
      resp_hit_41   <= 1'b0;
      busy_41       <= 1'b0;
    end else begin
      resp_valid_41 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            lk_addr_41  <= grant_src ? req1_addr_41 : req0_addr_41;
            cur_src     <= grant_src;
            lk_valid_41 <= 1'b1;
            busy_41     <= 1'b1;
            state       <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (lk_done_41) begin
            lk_valid_41 <= 1'b0;
            if (lk_hit_41 || NO_PENALTY) begin
              resp_valid_41 <= 1'b1;
              resp_src_41   <= cur_src;
              resp_hit_41   <= lk_hit_41;
              state         <= ST_RESP;
            end else begin
              refill_cnt <= REFILL_LOAD;
              state      <= ST_REFILL;
            end
          end
        end

        ST_REFILL: begin
          if (refill_cnt == 8'd0) begin
            resp_valid_41 <= 1'b1;
            resp_src_41   <= cur_src;
            resp_hit_41   <= 1'b0;
            state         <= ST_RESP;
          end else begin
            refill_cnt <= refill_cnt - 8'd1;
          end
        end

        ST_RESP: begin
          rr      <= ~cur_src;
          busy_41 <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          lk_valid_41 <= 1'b0;
          busy_41     <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Statistics update while the response is on the bus. resp_src_41 and
  // resp_hit_41 hold the served request's result for the whole RESP cycle.
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_41) begin
    if (rst_41) begin
      hits0_41   <= '0;
      misses0_41 <= '0;
      hits1_41   <= '0;
      misses1_41 <= '0;
    end else if (state == ST_RESP) begin
      case ({resp_src_41, resp_hit_41})
        2'b01: if (hits0_41   != CNT_MAX) hits0_41   <= hits0_41   + CNT_ONE;
        2'b00: if (misses0_41 != CNT_MAX) misses0_41 <= misses0_41 + CNT_ONE;
        2'b11: if (hits1_41   != CNT_MAX) hits1_41   <= hits1_41   + CNT_ONE;
        default: if (misses1_41 != CNT_MAX) misses1_41 <= misses1_41 + CNT_ONE;
      endcase
    end
  end
`else
  assign hits0_41   = '0;
  assign misses0_41 = '0;
  assign hits1_41   = '0;
  assign misses1_41 = '0;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_req_arbiter
//
// Directed bench for cache_req_arbiter with default parameters
// (ADDR_W 31, MISS_PENALTY 8, CNT_W 31). Inputs are driven on the falling
// edge and outputs are checked shortly after, so every check sees the state
// of the current cycle. Expected statistics depend on CACHE_ARB_STATS_EN.
// ---------------------------------------------------------------------------
module tb_cache_req_arbiter;

  localparam int ADDR_W = 31;
  localparam int CNT_W  = 31;

`ifdef CACHE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk_41;
  logic              rst_41;
  logic              req0_valid_41;
  logic [ADDR_W-1:0] req0_addr_41;
  logic              req0_ready_41;
  logic              req1_valid_41;
  logic [ADDR_W-1:0] req1_addr_41;
  logic              req1_ready_41;
  logic              lk_valid_41;
  logic [ADDR_W-1:0] lk_addr_41;
  logic              lk_done_41;
  logic              lk_hit_41;
  logic              resp_valid_41;
  logic              resp_src_41;
  logic              resp_hit_41;
  logic              busy_41;
  logic [CNT_W-1:0]  hits0_41;
  logic [CNT_W-1:0]  misses0_41;
  logic [CNT_W-1:0]  hits1_41;
  logic [CNT_W-1:0]  misses1_41;

  int checks;
  int errors;

  cache_req_arbiter dut (
    .clk_41        (clk_41),
    .rst_41        (rst_41),
    .req0_valid_41 (req0_valid_41),
    .req0_addr_41  (req0_addr_41),
    .req0_ready_41 (req0_ready_41),
    .req1_valid_41 (req1_valid_41),
    .req1_addr_41  (req1_addr_41),
    .req1_ready_41 (req1_ready_41),
    .lk_valid_41   (lk_valid_41),
    .lk_addr_41    (lk_addr_41),
    .lk_done_41    (lk_done_41),
    .lk_hit_41     (lk_hit_41),
    .resp_valid_41 (resp_valid_41),
    .resp_src_41   (resp_src_41),
    .resp_hit_41   (resp_hit_41),
    .busy_41       (busy_41),
    .hits0_41      (hits0_41),
    .misses0_41    (misses0_41),
    .hits1_41      (hits1_41),
    .misses1_41    (misses1_41)
  );

  // Free-running clock, period 10.
  initial clk_41 = 1'b0;
  always #5 clk_41 = ~clk_41;

  // Drive all request/core inputs for the current cycle, then let the
  // combinational readies settle before anything is checked.
  task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0,
                               input logic v1, input logic [ADDR_W-1:0] a1,
                               input logic done, input logic hit);
    req0_valid_41 = v0;
    req0_addr_41  = a0;
    req1_valid_41 = v1;
    req1_addr_41  = a1;
    lk_done_41    = done;
    lk_hit_41     = hit;
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts the failure and
  // reports tag, observed and expected values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleQuiet(input string tag);
    checkOutput({tag, " lk_valid"},   32'(lk_valid_41),   32'd0);
    checkOutput({tag, " resp_valid"}, 32'(resp_valid_41), 32'd0);
    checkOutput({tag, " busy"},       32'(busy_41),       32'd0);
  endtask

  task automatic checkStats(input string tag, input int h0, input int m0,
                            input int h1, input int m1);
    checkOutput({tag, " hits0"},   32'(hits0_41),   STATS ? 32'(h0) : 32'd0);
    checkOutput({tag, " misses0"}, 32'(misses0_41), STATS ? 32'(m0) : 32'd0);
    checkOutput({tag, " hits1"},   32'(hits1_41),   STATS ? 32'(h1) : 32'd0);
    checkOutput({tag, " misses1"}, 32'(misses1_41), STATS ? 32'(m1) : 32'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] fair_addr [2];
    int exp_src;

    checks = 0;
    errors = 0;
    fair_addr[0] = 31'h400;
    fair_addr[1] = 31'h800;

    // ---------------- Reset: two cycles ----------------
    rst_41 = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk_41);
    checkIdleQuiet("reset");
    checkOutput("reset lk_addr",   32'(lk_addr_41),    32'd0);
    checkOutput("reset resp_src",  32'(resp_src_41),   32'd0);
    checkOutput("reset resp_hit",  32'(resp_hit_41),   32'd0);
    checkOutput("reset ready0",    32'(req0_ready_41), 32'd0);
    checkOutput("reset ready1",    32'(req1_ready_41), 32'd0);
    checkStats("reset", 0, 0, 0, 0);
    rst_41 = 1'b0;

    // ---------------- Single hit, source 0, 0x100 ----------------
    @(negedge clk_41);                                   // cycle 0
    applyStimulus(1'b1, 31'h100, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("hit c0 ready0", 32'(req0_ready_41), 32'd1);
    checkOutput("hit c0 ready1", 32'(req1_ready_41), 32'd0);
    checkOutput("hit c0 busy",   32'(busy_41),       32'd0);
    @(negedge clk_41);                                   // cycle 1
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("hit c1 lk_valid", 32'(lk_valid_41),   32'd1);
    checkOutput("hit c1 lk_addr",  32'(lk_addr_41),    32'h100);
    checkOutput("hit c1 busy",     32'(busy_41),       32'd1);
    checkOutput("hit c1 resp",     32'(resp_valid_41), 32'd0);
    @(negedge clk_41);                                   // cycle 2
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("hit c2 resp_valid", 32'(resp_valid_41), 32'd1);
    checkOutput("hit c2 resp_src",   32'(resp_src_41),   32'd0);
    checkOutput("hit c2 resp_hit",   32'(resp_hit_41),   32'd1);
    checkOutput("hit c2 lk_valid",   32'(lk_valid_41),   32'd0);
    @(negedge clk_41);                                   // cycle 3
    checkIdleQuiet("hit c3");
    checkStats("hit c3", 1, 0, 0, 0);

    // ---------------- Miss stall, source 1, 0x2000 ----------------
    @(negedge clk_41);                                   // cycle 0
    applyStimulus(1'b0, '0, 1'b1, 31'h2000, 1'b0, 1'b0);
    checkOutput("miss c0 ready1", 32'(req1_ready_41), 32'd1);
    checkOutput("miss c0 ready0", 32'(req0_ready_41), 32'd0);
    @(negedge clk_41);                                   // cycle 1
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("miss c1 lk_valid", 32'(lk_valid_41), 32'd1);
    checkOutput("miss c1 lk_addr",  32'(lk_addr_41),  32'h2000);
    checkOutput("miss c1 busy",     32'(busy_41),     32'd1);
    for (int c = 2; c <= 9; c++) begin                   // cycles 2..9
      @(negedge clk_41);
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("miss c%0d busy", c),     32'(busy_41),       32'd1);
      checkOutput($sformatf("miss c%0d resp", c),     32'(resp_valid_41), 32'd0);
      checkOutput($sformatf("miss c%0d lk_valid", c), 32'(lk_valid_41),   32'd0);
    end
    @(negedge clk_41);                                   // cycle 10
    checkOutput("miss c10 resp_valid", 32'(resp_valid_41), 32'd1);
    checkOutput("miss c10 resp_src",   32'(resp_src_41),   32'd1);
    checkOutput("miss c10 resp_hit",   32'(resp_hit_41),   32'd0);
    @(negedge clk_41);                                   // cycle 11
    checkIdleQuiet("miss c11");
    checkStats("miss c11", 1, 0, 0, 1);

    // ---------------- Delayed done: two extra LOOKUP cycles ----------------
    @(negedge clk_41);                                   // cycle 0
    applyStimulus(1'b1, 31'h3C, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("dly c0 ready0", 32'(req0_ready_41), 32'd1);
    @(negedge clk_41);                                   // cycle 1
    applyStimulus(1'b0, 31'h7777, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("dly c1 lk_valid", 32'(lk_valid_41), 32'd1);
    @(negedge clk_41);                                   // cycle 2
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("dly c2 lk_valid", 32'(lk_valid_41), 32'd1);
    checkOutput("dly c2 lk_addr",  32'(lk_addr_41),  32'h3C);
    @(negedge clk_41);                                   // cycle 3
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("dly c3 lk_valid", 32'(lk_valid_41),   32'd1);
    checkOutput("dly c3 resp",     32'(resp_valid_41), 32'd0);
    @(negedge clk_41);                                   // cycle 4
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("dly c4 resp_valid", 32'(resp_valid_41), 32'd1);
    checkOutput("dly c4 resp_src",   32'(resp_src_41),   32'd0);
    checkOutput("dly c4 resp_hit",   32'(resp_hit_41),   32'd1);
    @(negedge clk_41);                                   // cycle 5
    checkStats("dly c5", 2, 0, 0, 1);

    // ---------------- Reset in the 4th REFILL cycle ----------------
    // Source 1 request; rr is 1 here so a lone source 1 is granted anyway.
    @(negedge clk_41);                                   // cycle 0
    applyStimulus(1'b0, '0, 1'b1, 31'h55, 1'b0, 1'b0);
    checkOutput("rst c0 ready1", 32'(req1_ready_41), 32'd1);
    @(negedge clk_41);                                   // cycle 1
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int c = 2; c <= 5; c++) begin                   // REFILL cycles 1..4
      @(negedge clk_41);
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("rst c%0d busy", c), 32'(busy_41), 32'd1);
    end
    rst_41 = 1'b1;                                       // in 4th REFILL cycle
    @(negedge clk_41);                                   // cycle 6
    rst_41 = 1'b0;
    checkIdleQuiet("rst c6");
    checkStats("rst c6", 0, 0, 0, 0);
    for (int c = 7; c <= 14; c++) begin
      @(negedge clk_41);
      checkOutput($sformatf("rst c%0d no resp", c), 32'(resp_valid_41), 32'd0);
      checkOutput($sformatf("rst c%0d busy", c),    32'(busy_41),       32'd0);
    end

    // ---------------- Fairness: both valid, six hits ----------------
    for (int i = 0; i < 6; i++) begin
      exp_src = i % 2;
      @(negedge clk_41);                                 // idle/accept
      applyStimulus(1'b1, fair_addr[0], 1'b1, fair_addr[1], 1'b0, 1'b0);
      checkOutput($sformatf("fair %0d ready0", i), 32'(req0_ready_41), 32'(exp_src == 0));
      checkOutput($sformatf("fair %0d ready1", i), 32'(req1_ready_41), 32'(exp_src == 1));
      @(negedge clk_41);                                 // lookup
      applyStimulus(1'b1, fair_addr[0], 1'b1, fair_addr[1], 1'b1, 1'b1);
      checkOutput($sformatf("fair %0d lk_addr", i), 32'(lk_addr_41), 32'(fair_addr[exp_src]));
      checkOutput($sformatf("fair %0d ready0 busy", i), 32'(req0_ready_41), 32'd0);
      @(negedge clk_41);                                 // response
      applyStimulus(1'b1, fair_addr[0], 1'b1, fair_addr[1], 1'b0, 1'b0);
      checkOutput($sformatf("fair %0d resp_valid", i), 32'(resp_valid_41), 32'd1);
      checkOutput($sformatf("fair %0d resp_src", i),   32'(resp_src_41),   32'(exp_src));
      checkOutput($sformatf("fair %0d resp_hit", i),   32'(resp_hit_41),   32'd1);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_41);
    checkIdleQuiet("fair end");
    checkStats("fair end", 3, 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Two-requester front end for the set-associative cache model. Arbitrates address requests from two sources (e.g. instruction and data streams) round-robin, issues one lookup at a time to the cache core, and models miss service as a fixed refill stall. Returns a per-request hit/miss response and can optionally keep per-source hit/miss counters.

## Interface
Parameters:
- `ADDR_W`, default 31: request and lookup address width.
- `MISS_PENALTY`, default 8: refill stall in cycles after a miss; legal range 0..255.
- `CNT_W`, default 31: statistics counter width.

Ports:
- `clk_41`, in, 1: single clock; all state updates on its rising edge.
- `rst_41`, in, 1: reset, synchronous, active-high.
- `req0_valid_41`, in, 1: source 0 request valid.
- `req0_addr_41`, in, ADDR_W: source 0 address.
- `req0_ready_41`, out, 1: source 0 request accepted this cycle.
- `req1_valid_41`, `req1_addr_41`, `req1_ready_41`: same signals for source 1.
- `lk_valid_41`, out, 1: lookup request to the cache core.
- `lk_addr_41`, out, ADDR_W: lookup address, latched at acceptance.
- `lk_done_41`, in, 1: cache core result valid; sampled only while `lk_valid_41` = 1.
- `lk_hit_41`, in, 1: 1 = hit, 0 = miss; qualified by `lk_done_41`.
- `resp_valid_41`, out, 1: one-cycle response pulse.
- `resp_src_41`, out, 1: source of the response (0 or 1).
- `resp_hit_41`, out, 1: hit/miss result of the response.
- `busy_41`, out, 1: high in every state except IDLE.
- `hits0_41`, `misses0_41`, `hits1_41`, `misses1_41`, out, CNT_W: per-source statistics.

## Operation
- The FSM has four states: IDLE, LOOKUP, REFILL, RESP.
- **IDLE**
  - If any valid is high, grant one source. `reqN_ready_41` is combinational and is high only in IDLE for the granted source.
  - On grant, latch the address and source, then go to LOOKUP.
  - Round-robin pointer `rr` (reset 0) names the preferred source. If both sources are valid, grant `rr`. If only one is valid, grant that one.
- **LOOKUP**
  - Hold `lk_valid_41` = 1 and keep `lk_addr_41` stable until `lk_done_41` = 1.
  - Done with hit: go to RESP.
  - Done with miss and `MISS_PENALTY` > 0: load the down-counter with `MISS_PENALTY`-1 and go to REFILL.
  - Done with miss and `MISS_PENALTY` = 0: go directly to RESP.
- **REFILL**
  - Decrement the counter each cycle. When it is 0, go to RESP.
  - The total REFILL dwell is exactly `MISS_PENALTY` cycles.
- **RESP**
  - Assert `resp_valid_41` for one cycle with the latched source and result.
  - Set `rr` to the opposite of the served source, then go to IDLE.
- Only one request is outstanding at a time. No ready is asserted outside IDLE.
- The response handshake has no backpressure: the consumer must take every `resp_valid_41` pulse.
- Statistics:
  - In RESP, increment the matching counter (`hitsN` or `missesN` for the served source).
  - Counters saturate at all-ones and never wrap.
- Reset: at the clock edge where `rst_41` = 1, the block goes to IDLE with `rr` = 0, the refill counter at 0 and all statistics at 0. Any in-flight request is dropped with no response.

## Timing
- Reset values: all readies 0 when no valid is present; `lk_valid_41` = 0; `lk_addr_41` = 0; `resp_valid_41` = 0; `resp_src_41` = 0; `resp_hit_41` = 0; `busy_41` = 0; all counters 0.
- Hit latency, with `lk_done_41` asserted in the first LOOKUP cycle:
  - accept in cycle 0;
  - LOOKUP in cycle 1;
  - `resp_valid_41` in cycle 2;
  - next accept possible in cycle 3.
- Miss latency is the hit latency plus `MISS_PENALTY` cycles. With the default of 8, `resp_valid_41` arrives in cycle 10.
- Each extra cycle of `lk_done_41` delay extends LOOKUP by one cycle.
- Maximum throughput is one request per 3 cycles.
- Both sources valid continuously: grants alternate 0, 1, 0, 1, …, starting with source 0 after reset.
- A valid that drops before it is granted is simply never served. The address is latched only on a grant.
- `rst_41` asserted during REFILL or LOOKUP: `lk_valid_41` and `busy_41` are 0 in the cycle after that edge.

## Configuration
- `CACHE_ARB_STATS_EN` defined: the four statistics counters are implemented as described above.
- `CACHE_ARB_STATS_EN` undefined: the counter logic is removed and the four statistics outputs are tied to 0. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst_41` for 2 cycles → all outputs at their reset values and `busy_41` = 0.
- **Single hit:** source 0 requests address 0x100 and the core answers done/hit in the first LOOKUP cycle → `req0_ready_41` in cycle 0, `resp_valid_41` in cycle 2 with src = 0 and hit = 1, `hits0_41` = 1.
- **Miss stall:** source 1 requests 0x2000 and the core answers miss, `MISS_PENALTY` = 8 → `resp_valid_41` in cycle 10 with hit = 0, `misses1_41` = 1, `busy_41` high in cycles 1–9.
- **Fairness:** both sources valid for 6 requests, all hits → grant order 0, 1, 0, 1, 0, 1; each `hitsN_41` = 3.
- **Reset mid-refill:** assert `rst_41` in the 4th REFILL cycle → no `resp_valid_41` pulse, state IDLE, counters 0, and the next request is granted to source 0.
- **Macro off:** build without `CACHE_ARB_STATS_EN` and rerun the fairness test → identical responses, all statistics outputs stay 0.
